// File: rtl/demux_stream_n.sv
// 1-to-NUM_CH valid/ready stream demultiplexer with one registered holding slot per channel.
// Optional per-channel take counters and a drop counter are built when DEMUX_STATS_EN is defined.
module demux_stream_n #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic                     sel_err
`ifdef DEMUX_STATS_EN
   ,
   output logic [NUM_CH*16-1:0]     beat_cnt,
   output logic [15:0]              drop_cnt
`endif
);

   // Handshake: a beat moves when in_valid & in_ready are both high at a rising edge; a
   // slot is handed over when out_valid[k] & out_ready[k]. in_ready never looks at in_valid.
   logic              sel_oor;
   logic              accept;
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] slot_free;

   assign sel_oor   = int'(in_sel) >= NUM_CH;
   assign slot_free = ~out_valid | out_ready;

   always_comb begin
      hit = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         hit[k] = (int'(in_sel) == k);
      end
   end

   // Out-of-range selects are always accepted so a bad beat can never wedge the producer.
   assign in_ready = sel_oor | (|(hit & slot_free));
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         out_data  <= '0;
         sel_err   <= 1'b0;
      end else begin
         sel_err <= accept & sel_oor;
         for (int k = 0; k < NUM_CH; k++) begin
            if (accept && hit[k]) begin
               out_valid[k]                  <= 1'b1;
               out_data[k*DATA_W +: DATA_W]  <= in_data;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

`ifdef DEMUX_STATS_EN
   logic [NUM_CH-1:0] take;

   assign take = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (take[k]) begin
               beat_cnt[k*16 +: 16] <= beat_cnt[k*16 +: 16] + 16'd1;
            end
         end
         if (accept && sel_oor) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
